// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch, data load/store) to one shared
// memory bus arbiter. One transaction outstanding at a time; the winning port's
// request is forwarded combinationally and the read response is routed back to it.
//
// Optional feature: define MEM_ARB_RR_EN for round-robin tie breaking
// (port not granted last wins). Without it, data always wins ties.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   PC / Inst_Req_*     instruction fetch request channel
//   Instruction / Inst_Valid / Inst_Ready      fetch response channel
//   Address / MemWrite / MemRead / Write_data / Write_strb / Mem_Req_Ready
//                       data request channel
//   Read_data / Read_data_Valid / Read_data_Ready   load response channel
//   mem_*               shared memory bus
//   inst_xfer_cnt       accepted instruction requests (wraps)
//   data_xfer_cnt       accepted data requests, reads plus writes (wraps)
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   PC,
    input  logic                Inst_Req_Valid,
    output logic                Inst_Req_Ready,
    output logic [DATA_W-1:0]   Instruction,
    output logic                Inst_Valid,
    input  logic                Inst_Ready,
    input  logic [ADDR_W-1:0]   Address,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic [DATA_W-1:0]   Write_data,
    input  logic [DATA_W/8-1:0] Write_strb,
    output logic                Mem_Req_Ready,
    output logic [DATA_W-1:0]   Read_data,
    output logic                Read_data_Valid,
    input  logic                Read_data_Ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic                mem_ren,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_req_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rdata_valid,
    output logic                mem_rdata_ready,
    output logic [31:0]         inst_xfer_cnt,
    output logic [31:0]         data_xfer_cnt
);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        I_REQ  = 5'b00010,
        I_RESP = 5'b00100,
        D_REQ  = 5'b01000,
        D_RESP = 5'b10000
    } state_t;

    state_t      r_state, w_next;
    logic [31:0] r_inst_cnt, r_data_cnt;
    logic        w_i_req, w_d_req, w_inst_hs, w_data_hs, w_data_wins;

    assign w_i_req = Inst_Req_Valid;
    assign w_d_req = MemRead | MemWrite;

`ifdef MEM_ARB_RR_EN
    // 1 = data was granted last. Resets to instruction so the first tie goes to data.
    logic r_last_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_last_data <= 1'b0;
        else if (w_inst_hs) r_last_data <= 1'b0;
        else if (w_data_hs) r_last_data <= 1'b1;
    end

    assign w_data_wins = ~r_last_data;
`else
    assign w_data_wins = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_inst_cnt <= '0;
            r_data_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_inst_hs) r_inst_cnt <= r_inst_cnt + 32'd1;
            if (w_data_hs) r_data_cnt <= r_data_cnt + 32'd1;
        end
    end

    always_comb begin
        w_next          = r_state;
        w_inst_hs       = 1'b0;
        w_data_hs       = 1'b0;
        Inst_Req_Ready  = 1'b0;
        Instruction     = '0;
        Inst_Valid      = 1'b0;
        Mem_Req_Ready   = 1'b0;
        Read_data       = '0;
        Read_data_Valid = 1'b0;
        mem_addr        = '0;
        mem_wen         = 1'b0;
        mem_ren         = 1'b0;
        mem_wdata       = '0;
        mem_wstrb       = '0;
        mem_rdata_ready = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_d_req && (!w_i_req || w_data_wins)) w_next = D_REQ;
                else if (w_i_req)                         w_next = I_REQ;
            end
            I_REQ: begin
                mem_ren        = Inst_Req_Valid;
                mem_addr       = PC;
                Inst_Req_Ready = mem_req_ready;
                w_inst_hs      = Inst_Req_Valid & mem_req_ready;
                if (w_inst_hs)           w_next = I_RESP;
                else if (!Inst_Req_Valid) w_next = IDLE;   // requester withdrew
            end
            I_RESP: begin
                Instruction     = mem_rdata;
                Inst_Valid      = mem_rdata_valid;
                mem_rdata_ready = Inst_Ready;
                if (mem_rdata_valid && Inst_Ready) w_next = IDLE;
            end
            D_REQ: begin
                mem_ren       = MemRead;
                mem_wen       = MemWrite;
                mem_addr      = Address;
                mem_wdata     = Write_data;
                mem_wstrb     = Write_strb;
                Mem_Req_Ready = mem_req_ready;
                w_data_hs     = w_d_req & mem_req_ready;
                // writes complete at the request handshake; only reads wait for data
                if (w_data_hs)    w_next = MemRead ? D_RESP : IDLE;
                else if (!w_d_req) w_next = IDLE;
            end
            D_RESP: begin
                Read_data       = mem_rdata;
                Read_data_Valid = mem_rdata_valid;
                mem_rdata_ready = Read_data_Ready;
                if (mem_rdata_valid && Read_data_Ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign inst_xfer_cnt = r_inst_cnt;
    assign data_xfer_cnt = r_data_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requester and memory models driven from queues, a
// scoreboard of expected bus grants and read responses, plus directed
// cycle-by-cycle checks for latency, stalls, reset and counter wrap.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] PC;
    logic        Inst_Req_Valid, Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid, Inst_Ready;
    logic [31:0] Address;
    logic        MemWrite, MemRead;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid, Read_data_Ready;
    logic [31:0] mem_addr;
    logic        mem_wen, mem_ren;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_req_ready;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid, mem_rdata_ready;
    logic [31:0] inst_xfer_cnt, data_xfer_cnt;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
        .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
        .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead),
        .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ready(Mem_Req_Ready),
        .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_req_ready(mem_req_ready),
        .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid), .mem_rdata_ready(mem_rdata_ready),
        .inst_xfer_cnt(inst_xfer_cnt), .data_xfer_cnt(data_xfer_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } dop_t;

    typedef struct {
        logic        wen;
        logic        ren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } gnt_t;

    logic [31:0] ipc_q[$];
    dop_t        dop_q[$];
    logic [31:0] iexp_q[$];
    logic [31:0] dexp_q[$];
    gnt_t        gnt_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    int req_wait = 0;
    bit flush = 1'b0;

    // memory contents: fixed word at 0x100, address-derived elsewhere
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic fetch(input logic [31:0] pc);
        ipc_q.push_back(pc);
        iexp_q.push_back(mem_f(pc));
    endtask

    task automatic dop(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
        dop_t d;
        d.wr = wr; d.addr = a; d.wdata = wd; d.strb = s;
        dop_q.push_back(d);
        if (!wr) dexp_q.push_back(mem_f(a));
    endtask

    task automatic exp_gnt(input logic wen, input logic ren, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] s);
        gnt_t g;
        g.wen = wen; g.ren = ren; g.addr = a; g.wdata = wd; g.strb = s;
        gnt_q.push_back(g);
    endtask

    // instruction requester: presents queued PCs, pops on handshake
    initial begin : i_req
        logic hs;
        PC = '0; Inst_Req_Valid = 1'b0;
        forever begin
            @(negedge clk);
            hs = Inst_Req_Valid & Inst_Req_Ready;
            @(posedge clk); #1;
            if (hs && ipc_q.size() != 0) void'(ipc_q.pop_front());
            Inst_Req_Valid = (ipc_q.size() != 0);
            PC = (ipc_q.size() != 0) ? ipc_q[0] : 32'h0;
        end
    end

    // data requester
    initial begin : d_req
        logic hs;
        dop_t d;
        Address = '0; MemRead = 1'b0; MemWrite = 1'b0; Write_data = '0; Write_strb = '0;
        forever begin
            @(negedge clk);
            hs = (MemRead | MemWrite) & Mem_Req_Ready;
            @(posedge clk); #1;
            if (hs && dop_q.size() != 0) void'(dop_q.pop_front());
            if (dop_q.size() != 0) begin
                d = dop_q[0];
                MemRead = ~d.wr; MemWrite = d.wr;
                Address = d.addr; Write_data = d.wdata; Write_strb = d.strb;
            end else begin
                MemRead = 1'b0; MemWrite = 1'b0;
                Address = '0; Write_data = '0; Write_strb = '0;
            end
        end
    end

    // memory: request ready after req_wait pending cycles, read data one cycle after accept
    initial begin : mem_mdl
        logic hs_req, hs_rsp, pend, rd;
        logic [31:0] a;
        int wcnt;
        wcnt = 0;
        mem_req_ready = 1'b1; mem_rdata = '0; mem_rdata_valid = 1'b0;
        forever begin
            @(negedge clk);
            pend   = mem_ren | mem_wen;
            hs_req = pend & mem_req_ready;
            hs_rsp = mem_rdata_valid & mem_rdata_ready;
            rd     = mem_ren;
            a      = mem_addr;
            @(posedge clk); #1;
            if (hs_rsp || flush) mem_rdata_valid = 1'b0;
            if (hs_req) begin
                wcnt = 0;
                if (rd) begin mem_rdata_valid = 1'b1; mem_rdata = mem_f(a); end
            end else if (pend) wcnt++;
            else wcnt = 0;
            mem_req_ready = (pend && !hs_req) ? (wcnt >= req_wait) : (req_wait == 0);
        end
    end

    // scoreboard: bus grants and routed read responses
    initial begin : mon
        gnt_t g;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst && (mem_ren || mem_wen) && mem_req_ready) begin
                if (gnt_q.size() != 0) g = gnt_q.pop_front();
                else begin g.wen = 1'b0; g.ren = 1'b0; g.addr = 'x; g.wdata = 'x; g.strb = 'x; end
                chk("gnt_rw", {mem_wen, mem_ren}, {g.wen, g.ren});
                chk("gnt_addr", mem_addr, g.addr);
                if (g.wen) begin
                    chk("gnt_wdata", mem_wdata, g.wdata);
                    chk("gnt_wstrb", mem_wstrb, g.strb);
                end
            end
            if (Inst_Valid && Inst_Ready) begin
                e = (iexp_q.size() != 0) ? iexp_q.pop_front() : 32'hxxxx_xxxx;
                chk("inst_rsp", Instruction, e);
            end
            if (Read_data_Valid && Read_data_Ready) begin
                e = (dexp_q.size() != 0) ? dexp_q.pop_front() : 32'hxxxx_xxxx;
                chk("data_rsp", Read_data, e);
            end
        end
    end

    task automatic chk_quiet(input string tag);
        chk({tag, "_hs"}, {Inst_Req_Ready, Inst_Valid, Mem_Req_Ready, Read_data_Valid,
                           mem_wen, mem_ren, mem_rdata_ready}, 0);
        chk({tag, "_bus"}, {mem_addr, mem_wdata}, 0);
        chk({tag, "_rdat"}, {Instruction, Read_data}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("rst");
        chk("rst_cnt", {inst_xfer_cnt, data_xfer_cnt}, 0);
        #1 rst = 1'b1;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((ipc_q.size() + dop_q.size() + iexp_q.size() + dexp_q.size() + gnt_q.size()) != 0
               && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_left"}, ipc_q.size() + dop_q.size() + iexp_q.size() + dexp_q.size() + gnt_q.size(), 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        Inst_Ready = 1'b1;
        Read_data_Ready = 1'b1;
        do_reset();

        // fetch 0x100: IDLE, I_REQ, I_RESP, IDLE
        @(negedge clk); #1;
        fetch(32'h100); exp_gnt(1'b0, 1'b1, 32'h100, '0, '0);
        @(negedge clk);
        chk("t1_idle", {mem_ren, Inst_Req_Ready}, 0);
        @(negedge clk);
        chk("t1_req", {mem_ren, mem_wen, Inst_Req_Ready}, 3'b101);
        chk("t1_addr", mem_addr, 32'h100);
        @(negedge clk);
        chk("t1_rsp", {Inst_Valid, mem_rdata_ready, Read_data_Valid}, 3'b110);
        chk("t1_inst", Instruction, 32'h0000_0013);
        @(negedge clk);
        chk("t1_cnt", inst_xfer_cnt, 1);
        chk("t1_idle2", {Inst_Valid, mem_rdata_ready, mem_ren}, 0);

        // store with 3 wait cycles: ready on 4th D_REQ cycle, no response phase
        @(negedge clk); #1;
        req_wait = 3;
        dop(1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011);
        exp_gnt(1'b1, 1'b0, 32'h200, 32'hDEAD_BEEF, 4'b0011);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_wait", {mem_wen, Mem_Req_Ready}, 2'b10);
        end
        @(negedge clk);
        chk("t2_hs", {mem_wen, Mem_Req_Ready, mem_wstrb}, 6'b11_0011);
        @(negedge clk);
        chk("t2_after", {Mem_Req_Ready, Read_data_Valid, mem_wen, mem_ren, mem_rdata_ready}, 0);
        chk("t2_cnt", data_xfer_cnt, 1);

        // load with consumer stalled 2 cycles in D_RESP
        #1;
        req_wait = 0;
        @(negedge clk); #1;
        Read_data_Ready = 1'b0;
        dop(1'b0, 32'h300, 32'h0, 4'h0); exp_gnt(1'b0, 1'b1, 32'h300, '0, '0);
        @(negedge clk);
        @(negedge clk);
        chk("t3_req", {mem_ren, Mem_Req_Ready}, 2'b11);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t3_hold", {Read_data_Valid, mem_rdata_ready, Inst_Valid}, 3'b100);
            chk("t3_data", Read_data, mem_f(32'h300));
        end
        @(posedge clk); #1;
        Read_data_Ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t3_done", {Read_data_Valid, mem_rdata_ready}, 0);
        chk("t3_cnt", data_xfer_cnt, 2);
        drain("t3");

        // simultaneous fetches and loads held continuously
        do_reset();
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            fetch(32'h400 + 32'(4 * i));
            dop(1'b0, 32'h500 + 32'(4 * i), 32'h0, 4'h0);
        end
`ifdef MEM_ARB_RR_EN
        for (int i = 0; i < 3; i++) begin
            exp_gnt(1'b0, 1'b1, 32'h500 + 32'(4 * i), '0, '0);
            exp_gnt(1'b0, 1'b1, 32'h400 + 32'(4 * i), '0, '0);
        end
`else
        for (int i = 0; i < 3; i++) exp_gnt(1'b0, 1'b1, 32'h500 + 32'(4 * i), '0, '0);
        for (int i = 0; i < 3; i++) exp_gnt(1'b0, 1'b1, 32'h400 + 32'(4 * i), '0, '0);
`endif
        drain("t4");
        chk("t4_cnt", {inst_xfer_cnt, data_xfer_cnt}, {32'd3, 32'd3});

        // reset while in I_RESP with the response stalled
        @(negedge clk); #1;
        Inst_Ready = 1'b0;
        fetch(32'h600); exp_gnt(1'b0, 1'b1, 32'h600, '0, '0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t5_resp", {Inst_Valid, mem_rdata_ready}, 2'b10);
        #1;
        rst = 1'b0;
        void'(iexp_q.pop_back());
        @(negedge clk);
        chk_quiet("t5_rst");
        chk("t5_cnt", {inst_xfer_cnt, data_xfer_cnt}, 0);
        #1;
        rst = 1'b1;
        Inst_Ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t5_late", {Inst_Valid, mem_rdata_ready, Instruction}, 0);
        end
        #1 flush = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        flush = 1'b0;

        // counter wrap
        @(negedge clk);
        force dut.r_inst_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_inst_cnt;
        #1;
        fetch(32'h700); exp_gnt(1'b0, 1'b1, 32'h700, '0, '0);
        drain("t6");
        chk("t6_wrap", inst_xfer_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
